// File: rtl/rf_alu_dm_mc.sv
// rf_alu_dm_mc: multi-cycle register-file / ALU / data-memory command engine.
// One command is processed at a time through IDLE, READ, EXEC, MEM, WB and DONE.
// Optional build macro RF_ALU_DM_MC_XZR_EN: when defined, the top register
// (index 2**RA_W-1) reads as zero on every port and writes to it are dropped.
module rf_alu_dm_mc #(
  parameter int DATA_W = 64,
  parameter int RA_W   = 5,
  parameter int MA_W   = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        cmd,
  input  logic [RA_W-1:0]   rd,
  input  logic [RA_W-1:0]   rn,
  input  logic [RA_W-1:0]   rm,
  input  logic [8:0]        imm9,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              err,
  input  logic [RA_W-1:0]   dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int RF_D = 2 ** RA_W;
  localparam int MEM_D = 2 ** MA_W;
  localparam logic [RA_W-1:0] XZR_IDX = {RA_W{1'b1}};

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_ORR  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_LDUR = 3'b100;
  localparam logic [2:0] OP_STUR = 3'b101;
  localparam logic [2:0] OP_CBZ  = 3'b110;
  localparam logic [2:0] OP_ILL  = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_EXEC = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t state_r, state_s;

  logic [2:0]        cmd_r;
  logic [RA_W-1:0]   rd_r, rn_r, rm_r;
  logic [8:0]        imm_r;
  logic [DATA_W-1:0] a_r, b_r;
  logic [DATA_W-1:0] result_r;
  logic              zero_r, busy_r, done_r, err_r;

  logic [DATA_W-1:0] rf_r  [RF_D];
  logic [DATA_W-1:0] mem_r [MEM_D];

  logic [DATA_W-1:0] rd_a_s, rd_b_s, dbg_s, alu_s;
  logic              rf_we_s, mem_we_s, load_s, exec_s, illegal_s;
  logic [MA_W-1:0]   maddr_s;

  assign busy     = busy_r;
  assign done     = done_r;
  assign err      = err_r;
  assign result   = result_r;
  assign zero     = zero_r;
  assign dbg_data = dbg_s;

  // Register-file read ports (operands and debug), with optional hard-wired zero register.
  always_comb begin
    rd_a_s = rf_r[rn_r];
    rd_b_s = rf_r[rm_r];
    dbg_s  = rf_r[dbg_addr];
`ifdef RF_ALU_DM_MC_XZR_EN
    if (rn_r == XZR_IDX) rd_a_s = {DATA_W{1'b0}};
    else                 rd_a_s = rf_r[rn_r];
    if (rm_r == XZR_IDX) rd_b_s = {DATA_W{1'b0}};
    else                 rd_b_s = rf_r[rm_r];
    if (dbg_addr == XZR_IDX) dbg_s = {DATA_W{1'b0}};
    else                     dbg_s = rf_r[dbg_addr];
`endif
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_r <= S_IDLE;
    else       state_r <= state_s;
  end

  // Next-state decode; the path through the states depends on the captured opcode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: if (start) state_s = S_READ; else state_s = S_IDLE;
      S_READ: if (illegal_s) state_s = S_DONE; else state_s = S_EXEC;
      S_EXEC: begin
        case (cmd_r)
          OP_LDUR, OP_STUR: state_s = S_MEM;
          OP_CBZ:           state_s = S_DONE;
          default:          state_s = S_WB;
        endcase
      end
      S_MEM:  if (cmd_r == OP_LDUR) state_s = S_WB; else state_s = S_DONE;
      S_WB:   state_s = S_DONE;
      S_DONE: state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // Datapath controls and ALU; address wraps by keeping only the low MA_W bits.
  always_comb begin
    illegal_s = (cmd_r == OP_ILL);
    exec_s    = (state_r == S_EXEC);
    load_s    = (state_r == S_MEM) && (cmd_r == OP_LDUR);
    mem_we_s  = (state_r == S_MEM) && (cmd_r == OP_STUR);
    rf_we_s   = (state_r == S_WB);
`ifdef RF_ALU_DM_MC_XZR_EN
    if (rd_r == XZR_IDX) rf_we_s = 1'b0;
    else                 rf_we_s = (state_r == S_WB);
`endif
    maddr_s = result_r[MA_W-1:0];
    case (cmd_r)
      OP_AND:           alu_s = a_r & b_r;
      OP_ORR:           alu_s = a_r | b_r;
      OP_ADD:           alu_s = a_r + b_r;
      OP_SUB:           alu_s = a_r - b_r;
      OP_LDUR, OP_STUR: alu_s = a_r + {{(DATA_W-9){imm_r[8]}}, imm_r};
      OP_CBZ:           alu_s = b_r + {DATA_W{1'b0}};
      default:          alu_s = {DATA_W{1'b0}};
    endcase
  end

  // Capture the command fields on acceptance so inputs may change afterwards.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cmd_r <= 3'b000;
      rd_r  <= {RA_W{1'b0}};
      rn_r  <= {RA_W{1'b0}};
      rm_r  <= {RA_W{1'b0}};
      imm_r <= 9'd0;
    end else if (state_r == S_IDLE && start) begin
      cmd_r <= cmd;
      rd_r  <= rd;
      rn_r  <= rn;
      rm_r  <= rm;
      imm_r <= imm9;
    end
  end

  // Operand latches loaded in READ.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_r <= {DATA_W{1'b0}};
      b_r <= {DATA_W{1'b0}};
    end else if (state_r == S_READ) begin
      a_r <= rd_a_s;
      b_r <= rd_b_s;
    end
  end

  // Result and zero flag: ALU value leaving EXEC, load data replaces result leaving MEM.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      result_r <= {DATA_W{1'b0}};
      zero_r   <= 1'b0;
    end else if (exec_s) begin
      result_r <= alu_s;
      zero_r   <= (alu_s == {DATA_W{1'b0}});
    end else if (load_s) begin
      result_r <= mem_r[maddr_s];
    end
  end

  // Status outputs registered from the next state so they line up with the state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      busy_r <= (state_s != S_IDLE);
      done_r <= (state_s == S_DONE);
      err_r  <= (state_s == S_DONE) && illegal_s;
    end
  end

  // Register file: cleared by reset, written only at the edge leaving WB.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RF_D; i++) rf_r[i] <= {DATA_W{1'b0}};
    end else if (rf_we_s) begin
      rf_r[rd_r] <= result_r;
    end
  end

  // Data memory: contents survive reset; a store is suppressed while reset is high.
  always_ff @(posedge clock) begin
    if (mem_we_s && !reset) mem_r[maddr_s] <= b_r;
  end

endmodule

// File: tb/tb_rf_alu_dm_mc.sv
// Directed self-checking bench for rf_alu_dm_mc with a scoreboard of expected
// completions and a small reference model of the register file and memory.
module tb_rf_alu_dm_mc;

  logic        clock = 1'b0;
  logic        reset, start;
  logic [2:0]  cmd;
  logic [4:0]  rd, rn, rm, dbg_addr;
  logic [8:0]  imm9;
  logic        busy, done, zero, err;
  logic [63:0] result, dbg_data;

  rf_alu_dm_mc dut (
    .clock(clock), .reset(reset), .start(start), .cmd(cmd),
    .rd(rd), .rn(rn), .rm(rm), .imm9(imm9),
    .busy(busy), .done(done), .result(result), .zero(zero), .err(err),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [63:0] res;
    logic        z;
    logic        e;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [63:0] rf_m  [32];
  logic [63:0] mem_m [256];
  logic [63:0] last_res;
  logic        last_z;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rd_model(input int idx);
`ifdef RF_ALU_DM_MC_XZR_EN
    if (idx == 31) return 64'd0;
`endif
    return rf_m[idx];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) rf_m[i] = 64'd0;
    last_res = 64'd0;
    last_z   = 1'b0;
  endtask

  // Compute the expected completion of one command and push it.
  task automatic model_push(input logic [2:0] c, input int d, input int n, input int m,
                            input logic [8:0] imm);
    logic [63:0] a, b, r, sext;
    exp_t        x;
    a    = rd_model(n);
    b    = rd_model(m);
    sext = {{55{imm[8]}}, imm};
    case (c)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: r = a + b;
      3'd3: r = a - b;
      3'd4, 3'd5: r = a + sext;
      3'd6: r = b;
      default: r = last_res;
    endcase
    x.z = (c == 3'd7) ? last_z : (r == 64'd0);
    x.e = (c == 3'd7);
    x.res = r;
    if (c == 3'd4) x.res = mem_m[r[7:0]];
    if (c == 3'd5) mem_m[r[7:0]] = b;
    if (c <= 3'd4) begin
`ifdef RF_ALU_DM_MC_XZR_EN
      if (d != 31) rf_m[d] = x.res;
`else
      rf_m[d] = x.res;
`endif
    end
    case (c)
      3'd4: x.lat = 5;
      3'd6: x.lat = 3;
      3'd7: x.lat = 2;
      default: x.lat = 4;
    endcase
    last_res = x.res;
    last_z   = x.z;
    sb.push_back(x);
  endtask

  // Issue a command, optionally pulse start again or assert reset mid-flight,
  // then pop the scoreboard when done appears.
  task automatic run(input string tag, input logic [2:0] c, input int d, input int n,
                     input int m, input logic [8:0] imm, input int pulse_at, input int reset_at);
    int   cnt;
    bit   seen;
    exp_t x;
    model_push(c, d, n, m, imm);
    @(negedge clock);
    start = 1'b1; cmd = c; rd = 5'(d); rn = 5'(n); rm = 5'(m); imm9 = imm;
    cnt = 0; seen = 0;
    while (!seen && cnt < 20) begin
      @(negedge clock);
      cnt++;
      if (cnt == pulse_at) begin
        start = 1'b1; cmd = 3'd2; rd = 5'd10; rn = 5'd2; rm = 5'd3;
      end else begin
        start = 1'b0;
        cmd = 3'($urandom_range(0, 7)); rd = 5'($urandom_range(0, 31));
        rn = 5'($urandom_range(0, 31)); rm = 5'($urandom_range(0, 31));
        imm9 = 9'($urandom_range(0, 511));
      end
      if (cnt == 1) chk({tag, "_busy"}, {63'd0, busy}, 64'd1);
      if (cnt == reset_at) begin
        reset = 1'b1;
        #1;
        chk({tag, "_rst_busy"}, {63'd0, busy}, 64'd0);
        chk({tag, "_rst_done"}, {63'd0, done}, 64'd0);
        chk({tag, "_rst_result"}, result, 64'd0);
        void'(sb.pop_front());
        model_reset();
        @(negedge clock);
        reset = 1'b0;
        return;
      end
      if (done) seen = 1;
    end
    x = sb.pop_front();
    chk({tag, "_seen"}, {63'd0, seen}, 64'd1);
    chk({tag, "_lat"}, 64'(cnt), 64'(x.lat));
    chk({tag, "_result"}, result, x.res);
    chk({tag, "_zero"}, {63'd0, zero}, {63'd0, x.z});
    chk({tag, "_err"}, {63'd0, err}, {63'd0, x.e});
  endtask

  task automatic dbg_all(input string tag);
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      #1;
      chk($sformatf("%s_rf%0d", tag, i), dbg_data, rd_model(i));
    end
  endtask

  task automatic dbg_one(input string tag, input int idx, input logic [63:0] exp);
    dbg_addr = 5'(idx);
    #1;
    chk(tag, dbg_data, exp);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; cmd = 3'd0; rd = 5'd0; rn = 5'd0; rm = 5'd0;
    imm9 = 9'd0; dbg_addr = 5'd0;
    model_reset();
    for (int i = 0; i < 256; i++) mem_m[i] = 64'd0;
    #12;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_err", {63'd0, err}, 64'd0);
    chk("rst_zero", {63'd0, zero}, 64'd0);
    chk("rst_result", result, 64'd0);
    @(negedge clock);
    reset = 1'b0;
    dbg_all("rst");

    // ADD of zero registers
    run("add0", 3'd2, 1, 0, 0, 9'd0, 0, 0);
    dbg_one("add0_rf1", 1, 64'd0);

    // memory image 5/7 loaded into RF[2], RF[3]
    dut.mem_r[10] <= 64'd5;
    dut.mem_r[11] <= 64'd7;
    mem_m[10] = 64'd5;
    mem_m[11] = 64'd7;
    run("ld2", 3'd4, 2, 0, 0, 9'd10, 0, 0);
    run("ld3", 3'd4, 3, 0, 0, 9'd11, 0, 0);
    run("sub", 3'd3, 4, 2, 3, 9'd0, 0, 0);
    dbg_one("sub_rf4", 4, 64'hFFFF_FFFF_FFFF_FFFE);
    run("and", 3'd0, 6, 2, 3, 9'd0, 0, 0);
    run("orr", 3'd1, 7, 2, 3, 9'd0, 0, 0);
    run("add", 3'd2, 8, 2, 3, 9'd0, 0, 0);
    dbg_one("add_rf8", 8, 64'd12);

    // store to address -1 wraps to word 255, then load it back
    run("stur", 3'd5, 0, 0, 3, 9'h1FF, 0, 0);
    chk("stur_mem255", dut.mem_r[255], 64'd7);
    run("ldur", 3'd4, 5, 0, 0, 9'h1FF, 0, 0);
    dbg_one("ldur_rf5", 5, 64'd7);

    run("cbz0", 3'd6, 0, 0, 0, 9'd0, 0, 0);
    run("cbz7", 3'd6, 0, 0, 3, 9'd0, 0, 0);

    // illegal opcode leaves everything untouched
    run("ill", 3'd7, 4, 2, 3, 9'd0, 0, 0);
    dbg_all("ill");

    // writes to the top register
    run("xzr", 3'd1, 31, 2, 3, 9'd0, 0, 0);
`ifdef RF_ALU_DM_MC_XZR_EN
    dbg_one("xzr_rf31", 31, 64'd0);
`else
    dbg_one("xzr_rf31", 31, 64'd7);
`endif

    // start while busy is ignored
    run("ign", 3'd6, 0, 0, 2, 9'd0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("ign_idle_busy", {63'd0, busy}, 64'd0);
      chk("ign_idle_done", {63'd0, done}, 64'd0);
    end
    dbg_one("ign_rf10", 10, 64'd0);

    // reset asserted in WB aborts the write
    run("abort", 3'd2, 9, 2, 3, 9'd0, 1, 3);
    dbg_all("abort");

    // memory survives reset and the first start afterwards is taken
    run("postrst", 3'd4, 5, 0, 0, 9'h1FF, 0, 0);
    dbg_one("postrst_rf5", 5, 64'd7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rf_alu_dm_mc.md
RF_ALU_DM_MC -- requirements
Module: rf_alu_dm_mc

Interface
REQ-001 Parameter DATA_W, default 64: datapath, register and memory word width in bits; at least 16.
REQ-002 Parameter RA_W, default 5: register address width; register file depth is 2**RA_W.
REQ-003 Parameter MA_W, default 8: data memory word-address width; memory depth is 2**MA_W words.
REQ-004 Port clock, input, 1: single clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1: reset, asynchronous and active-high.
REQ-006 Port start, input, 1: command request; sampled only while idle.
REQ-007 Port cmd, input, 3: opcode. 000 AND, 001 ORR, 010 ADD, 011 SUB, 100 LDUR, 101 STUR, 110 CBZ, 111 illegal.
REQ-008 Ports rd, rn, rm, input, RA_W each: destination, first source and second source register.
REQ-009 Port imm9, input, 9: signed offset for LDUR and STUR.
REQ-010 Port busy, output, 1: high whenever the state is not IDLE.
REQ-011 Port done, output, 1: one-cycle completion pulse.
REQ-012 Port result, output, DATA_W: registered ALU result, or load data for LDUR.
REQ-013 Port zero, output, 1: registered flag, high when the ALU result equals 0.
REQ-014 Port err, output, 1: high together with done when the completed command was illegal.
REQ-015 Ports dbg_addr (input, RA_W) and dbg_data (output, DATA_W): combinational register-file read port for debug.

Function
REQ-016 States IDLE, READ, EXEC, MEM, WB, DONE.
REQ-017 Command accept: start=1 in IDLE captures cmd/rd/rn/rm/imm9 into registers and moves to READ. Inputs may change afterwards.
REQ-018 start is ignored when not in IDLE.
REQ-019 READ: latch A=RF[rn]; latch B=RF[rm] (the Rt operand for STUR/CBZ is taken from rm).
REQ-020 EXEC result:
- R-type: A op B.
- LDUR/STUR: A + sign_extend(imm9) to DATA_W.
- CBZ: B + 0.
- SUB is two's complement; carry and overflow are discarded; all arithmetic is modulo 2**DATA_W.
REQ-021 Memory word address is the low MA_W bits of the EXEC result; upper bits are ignored and the address wraps.
REQ-022 Transitions:
- R-type: READ->EXEC->WB->DONE.
- LDUR: READ->EXEC->MEM->WB->DONE.
- STUR: READ->EXEC->MEM->DONE.
- CBZ: READ->EXEC->DONE.
- Illegal: READ->DONE.
- DONE->IDLE always.
REQ-023 Latency with start sampled at edge 0: done is high in cycle 4 for R-type, 5 for LDUR, 4 for STUR, 3 for CBZ and 2 for illegal.
REQ-024 STUR writes B to memory at the edge leaving MEM. LDUR reads memory in MEM and writes RF[rd] at the edge leaving WB.
REQ-025 The register file is written only at the edge leaving WB. Illegal commands, STUR and CBZ change no register; illegal commands also change no memory and keep result and zero unchanged.
REQ-026 A write followed by a read of the same register in the next command returns the new value.
REQ-027 dbg_data reflects a write from the cycle after the write edge.
REQ-028 result and zero update at the edge leaving EXEC; for LDUR, result updates again at the edge leaving MEM. Both hold until the next update.
REQ-029 A new command may be accepted in the IDLE cycle that immediately follows DONE.

Reset
REQ-030 Asynchronous assertion of reset forces: state IDLE; busy, done, err, zero = 0; result = 0; all registers = 0.
REQ-031 Reset asserted mid-command aborts the command. A pending register write or memory write at that edge does not occur.
REQ-032 Data memory contents are not cleared by reset.
REQ-033 After reset deasserts, the first rising edge with start=1 is accepted.

Configuration
REQ-034 Macro RF_ALU_DM_MC_XZR_EN.
- Defined: register 2**RA_W-1 reads as 0 on all ports, and writes to it are discarded.
- Undefined: that register is an ordinary register.

Verification
REQ-035 Reset, then ADD with rd=1, rn=0, rm=0 -> done in cycle 4; result=0; zero=1; RF[1]=0.
REQ-036 Preload RF[2]=5 and RF[3]=7 via a 5/7 memory image and LDUR, then SUB rd=4, rn=2, rm=3 -> RF[4]=0xFFFF_FFFF_FFFF_FFFE; zero=0.
REQ-037 STUR rm=3, rn=0, imm9=-1 -> memory word 255 = 7 (address wrap); then LDUR rd=5 with the same address -> RF[5]=7 and done in cycle 5.
REQ-038 cmd=111 -> done in cycle 2 with err=1; dbg reads show all registers unchanged.
REQ-039 start pulsed while busy, then reset asserted in WB -> second start ignored; the WB write does not occur; busy=0 immediately.
REQ-040 XZR_EN defined: ORR rd=31 with nonzero sources, then read dbg_addr=31 -> 0. Undefined: same stimulus -> the ORR value.
